// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display blocks.
package seg_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam logic [NUM_DIGITS-1:0] ANODE_OFF = 4'b1111;

    typedef enum logic [1:0] {
        SLOT0 = 2'd0,
        SLOT1 = 2'd1,
        SLOT2 = 2'd2,
        SLOT3 = 2'd3
    } slot_t;

    // Active-low one-hot anode pattern for a digit index.
    function automatic logic [NUM_DIGITS-1:0] onehot_low(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Load/display bundle between the CPU/debug side and the scan controller.
interface seg_scan_ctrl_if;
    logic [15:0] value;
    logic [3:0]  dp_in;
    logic        load;
    logic        blank_lz;
    logic [3:0]  anode;
    logic [3:0]  digit;
    logic        dp;
    logic        frame_done;

    modport master (
        output value, dp_in, load, blank_lz,
        input  anode, digit, dp, frame_done
    );

    modport slave (
        input  value, dp_in, load, blank_lz,
        output anode, digit, dp, frame_done
    );
endinterface

// File: rtl/seg_tick_gen.sv
// Free-running prescaler: one-cycle tick every REFRESH_DIV clocks.
module seg_tick_gen #(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic CLK,
    input  logic Reset,
    output logic tick
);
    localparam int unsigned W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(REFRESH_DIV - 1);

    logic [W-1:0] div_cnt;

    always_ff @(posedge CLK) begin
        if (Reset || tick)
            div_cnt <= '0;
        else
            div_cnt <= div_cnt + 1'b1;
    end

    assign tick = (div_cnt == LAST);

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scan controller with frame-synchronous
// value updates, leading-zero blanking and per-digit decimal points.
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 100000
) (
    input  logic           CLK,
    input  logic           Reset,
    seg_scan_ctrl_if.slave bus
);
    logic        tick;
    logic        boundary;
    slot_t       slot, slot_nxt;
    logic [15:0] shown, shown_nxt, pend;
    logic [3:0]  shown_dp, shown_dp_nxt, pend_dp;
    logic        pending;
    logic [3:0]  anode_nxt, digit_nxt;
    logic        dp_nxt;
    logic        nonzero_lead;

    seg_tick_gen #(.REFRESH_DIV(REFRESH_DIV)) u_tick (
        .CLK   (CLK),
        .Reset (Reset),
        .tick  (tick)
    );

    always_ff @(posedge CLK) begin
        if (Reset)
            slot <= SLOT3;
        else
            slot <= slot_nxt;
    end

    always_comb begin
        slot_nxt = slot;
        if (tick) begin
            case (slot)
                SLOT0:   slot_nxt = SLOT1;
                SLOT1:   slot_nxt = SLOT2;
                SLOT2:   slot_nxt = SLOT3;
                default: slot_nxt = SLOT0;
            endcase
        end
    end

    assign boundary = tick && (slot_nxt == SLOT0);

    // Selection looks at the post-boundary value so digit 0 of a new frame
    // already shows a freshly applied load.
    always_comb begin
        shown_nxt    = shown;
        shown_dp_nxt = shown_dp;
        if (boundary && pending) begin
            shown_nxt    = pend;
            shown_dp_nxt = pend_dp;
        end
        nonzero_lead = 1'b0;
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if (j >= int'(slot_nxt) && shown_nxt[4*j +: 4] != 4'h0)
                nonzero_lead = 1'b1;
        end
        digit_nxt = shown_nxt[{slot_nxt, 2'b00} +: 4];
        dp_nxt    = ~shown_dp_nxt[slot_nxt];
        if (bus.blank_lz && slot_nxt != SLOT0 && !nonzero_lead)
            anode_nxt = ANODE_OFF;
        else
            anode_nxt = onehot_low(slot_nxt);
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            shown          <= '0;
            shown_dp       <= '0;
            pend           <= '0;
            pend_dp        <= '0;
            pending        <= 1'b0;
            bus.anode      <= ANODE_OFF;
            bus.digit      <= '0;
            bus.dp         <= 1'b1;
            bus.frame_done <= 1'b0;
        end else begin
            shown    <= shown_nxt;
            shown_dp <= shown_dp_nxt;
            // A load coincident with the boundary stays pending for the next frame.
            if (bus.load) begin
                pend    <= bus.value;
                pend_dp <= bus.dp_in;
                pending <= 1'b1;
            end else if (boundary) begin
                pending <= 1'b0;
            end
            if (tick) begin
                bus.anode <= anode_nxt;
                bus.digit <= digit_nxt;
                bus.dp    <= dp_nxt;
            end
            bus.frame_done <= boundary;
        end
    end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexing scan controller for the 4-digit common-anode seven-segment display on the board. It holds a 16-bit hex value loaded by the CPU top or debug logic and cycles the anodes one digit at a time. Each lit digit's nibble goes to the existing hex-to-segment decoder, whose segment code is active-low. Values are applied only at frame boundaries to prevent tearing, with optional leading-zero blanking and per-digit decimal points.

Parameters:
REFRESH_DIV, 100000, clock cycles per digit slot (100 MHz gives 1 kHz per digit, 250 Hz per frame); legal range >= 1

Ports:
CLK  input  1  system clock, all logic on rising edge
Reset  input  1  synchronous, active-high reset
value  input  16  hex value; digit i = value[4i+3:4i], digit 0 rightmost
dp_in  input  4  decimal-point enables, bit i = digit i, 1 = on
load  input  1  1-cycle strobe; captures value/dp_in into pending register
blank_lz  input  1  1 = blank leading zero digits (live, sampled each tick)
anode  output  4  active-low digit enables, at most one bit low
digit  output  4  nibble for the currently lit digit, to decoder
dp  output  1  active-low decimal point for the lit digit
frame_done  output  1  1-cycle pulse when scan wraps to digit 0

Behaviour:
- Reset (any cycle, including mid-frame): div_cnt=0, idx=3, shown=0, shown_dp=0, pend=0, pend_dp=0, pending=0, anode=4'b1111, digit=0, dp=1, frame_done=0. Any pending load is discarded.
- Prescaler: div_cnt counts 0..REFRESH_DIV-1 and wraps. tick is asserted in the cycle where div_cnt==REFRESH_DIV-1. With REFRESH_DIV=1, tick is asserted every cycle.
- On tick: idx <= idx+1 mod 4 (3 wraps to 0). anode, digit and dp are registered and update in the same edge to reflect the new idx. The first tick after reset therefore lights digit 0.
- Frame boundary is a tick where the new idx==0:
  - If pending=1: shown<=pend, shown_dp<=pend_dp, pending<=0. Digit 0 of the new frame already uses the new value (selection uses the next-state shown).
  - frame_done=1 for exactly that cycle, then returns to 0.
- load: pend<=value, pend_dp<=dp_in, pending<=1 on any cycle. A later load before the boundary overwrites pend (last load wins).
- load in the same cycle as a boundary tick: the boundary transfers the old pend, if pending. The new capture stays pending and applies at the next boundary.
- Outputs for lit digit k:
  - digit = shown[4k+3:4k]
  - dp = ~shown_dp[k]
  - anode = all ones except bit k = 0
- Leading-zero blanking: if blank_lz=1, k!=0, and shown digits k..3 are all zero, then anode=4'b1111 for that slot. digit and dp are still driven but are don't-care. Digit 0 is never blanked, so value 0 shows a single "0".
- Between ticks, outputs hold. No combinational path exists from inputs to outputs.
- Frame period = 4*REFRESH_DIV cycles. Latency from load to visible is at most one frame plus one slot.

Decomposition:
- Shared package, seg_pkg:
  - NUM_DIGITS=4
  - ANODE_OFF=4'b1111
  - function onehot_low(idx), returning the active-low one-hot anode pattern for a digit index
- Sub-module seg_tick_gen: parameterised prescaler (REFRESH_DIV) producing the tick pulse. It is reused by later blink/debounce blocks.
- The hex decoder is instantiated beside this block at the top level, not inside it.

Test Plan:
- Reset, REFRESH_DIV=4, no load -> anode=1111 until the first tick (cycle 4). Then anode 1110, 1101, 1011, 0111 every 4 cycles, digit=0 throughout. frame_done pulses at cycles 4, 20, 36.
- load value=16'h1A2F, dp_in=4'b0100 mid-frame -> no change until the next boundary. Then per-slot digit=F,2,A,1 and dp=1,1,0,1.
- Two loads (16'h1111 then 16'h2222) before a boundary -> next frame shows 2222 only. A load coincident with a boundary tick (16'h3333) -> the current frame keeps the old value and 3333 appears one frame later.
- blank_lz=1, value=16'h0050 -> digits 3 and 2 have anode=1111 in their slots, digits 1 and 0 are lit (5, 0). value=16'h0000 -> only digit 0 lit, showing 0.
- Reset asserted mid-frame with a load pending -> next edge: all outputs at reset values and pending=0. After release, 0000 is displayed and the scan restarts at digit 0 on the first tick.
- REFRESH_DIV=1 -> anode rotates every cycle and frame_done pulses every 4 cycles. Check that at most one anode bit is low in every cycle (assertion).
